// File: rtl/loader_write_queue_pkg.sv
// Shared constants and types for the loader write queue.
// Defines the default address/data widths, the FIFO depth, the nes_ce value
// that opens an SDRAM write slot, and the packed {addr, data} write record.
package loader_write_queue_pkg;

  localparam int         LDR_ADDR_W  = 22;
  localparam int         LDR_DATA_W  = 8;
  localparam int         LDR_DEPTH   = 8;
  localparam logic [1:0] LDR_CE_SLOT = 2'd3;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [LDR_DATA_W-1:0] data;
  } ldr_wr_t;

endpackage

// File: rtl/loader_write_queue_if.sv
// Write-side bus of the loader write queue.
//  in_valid/in_addr/in_data : 1-cycle write pulses coming from game_loader
//  out_we/out_addr/out_data : replayed writes towards SDRAM port A
// master = producer of writes / consumer of port-A signals (loader side, bench)
// slave  = the queue itself
interface loader_write_queue_if
  import loader_write_queue_pkg::*;
#(
  parameter int ADDR_W = LDR_ADDR_W,
  parameter int DATA_W = LDR_DATA_W
);

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_addr, in_data,
    input  out_we, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output out_we, out_addr, out_data
  );

endinterface

// File: rtl/loader_write_queue_sync_fifo.sv
// Generic synchronous FIFO with register-array storage.
//  clock, R_reset : clock and synchronous active-high reset
//  push, din      : write request and data; ignored when full unless pop is also set
//  pop, dout      : read request; dout always shows the head entry (first-word fall-through)
//  full, empty    : derived from level, not from pointer equality
//  level          : registered occupancy, 0..DEPTH
module loader_write_queue_sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     R_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take a push.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[head];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (R_reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop_ok) begin
        head <= head + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        level <= level + LVL_W'(1);
      end else if (pop_ok && !push_ok) begin
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/loader_write_queue.sv
// Buffers game_loader byte writes and replays them to SDRAM port A, one write per
// NES memory slot (nes_ce == CE_SLOT), each held stable for the full 4-clock slot.
//  clock, R_reset : NES system clock, synchronous active-high reset
//  wq (slave)     : loader write pulses in, port-A write enable/address/data out
//  in_load_done   : game_loader done level
//  nes_ce         : free-running 2-bit NES divider
//  load_done      : loader done and every buffered write retired
//  busy           : FIFO non-empty or a write is on the bus
//  overflow       : sticky, a write was dropped on a full FIFO
//  level          : FIFO occupancy
module loader_write_queue
  import loader_write_queue_pkg::*;
#(
  parameter int         ADDR_W  = LDR_ADDR_W,
  parameter int         DATA_W  = LDR_DATA_W,
  parameter int         DEPTH   = LDR_DEPTH,
  parameter logic [1:0] CE_SLOT = LDR_CE_SLOT
) (
  input  logic                   clock,
  input  logic                   R_reset,
  loader_write_queue_if.slave    wq,
  input  logic                   in_load_done,
  input  logic [1:0]             nes_ce,
  output logic                   load_done,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int WR_W  = ADDR_W + DATA_W;

  logic              slot;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WR_W-1:0]   fifo_dout;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [LVL_W-1:0]  level_nxt;
  logic              we_nxt;
  logic              out_we_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  assign slot    = (nes_ce == CE_SLOT);
  assign pop     = slot && !fifo_empty;
  assign push_ok = wq.in_valid && (!fifo_full || pop);
  assign drop    = wq.in_valid && fifo_full && !pop;

  loader_write_queue_sync_fifo #(
    .WIDTH (WR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .R_reset (R_reset),
    .push    (wq.in_valid),
    .pop     (pop),
    .din     ({wq.in_addr, wq.in_data}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // busy and load_done are registered, so they look at the occupancy and write
  // enable that this same edge will produce rather than the current ones.
  always_comb begin
    level_nxt = level;
    if (push_ok && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !push_ok) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  assign we_nxt = slot ? !fifo_empty : out_we_q;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      // Port-A signals move only on slot edges; an empty slot keeps the last address/data.
      if (slot) begin
        out_we_q <= !fifo_empty;
        if (!fifo_empty) begin
          {out_addr_q, out_data_q} <= fifo_dout;
        end
      end
      overflow  <= overflow | drop;
      busy      <= (level_nxt != '0) || we_nxt;
      load_done <= in_load_done && (level_nxt == '0) && !we_nxt;
    end
  end

  assign wq.out_we   = out_we_q;
  assign wq.out_addr = out_addr_q;
  assign wq.out_data = out_data_q;

endmodule
